// File: rtl/serializer_if.sv
// Parallel-load / serial-out link between an upstream word source and the serializer.
// The master drives words and the bit-rate strobe; the slave returns the serial stream and status.
interface serializer_if #(
    parameter int bus_width = 8
);
    logic                 load_valid;
    logic [bus_width-1:0] p_data;
    logic                 shift_en;
    logic                 load_ready;
    logic                 s_data;
    logic                 s_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output load_valid, p_data, shift_en,
        input  load_ready, s_data, s_valid, busy, done
    );

    modport slave (
        input  load_valid, p_data, shift_en,
        output load_ready, s_data, s_valid, busy, done
    );
endinterface

// File: rtl/serializer.sv
// MSB-first parallel-to-serial converter: accepts a word in IDLE, emits one bit per shift_en
// cycle in SHIFT, and pulses done for one cycle after the last bit.
//
// state | meaning
// IDLE  | ready for a word; shift_en ignored
// SHIFT | frame in progress; one bit per cycle with shift_en=1
module serializer #(
    parameter int bus_width   = 8,
    parameter int counter_reg = $clog2(bus_width)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    serializer_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [counter_reg-1:0] LAST_BIT = counter_reg'(bus_width - 1);

    state_t                 state_q, state_d;
    logic [bus_width-1:0]   shift_q, shift_d;
    logic [counter_reg-1:0] cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   bit_fire;

    assign bit_fire       = (state_q == SHIFT) && bus.shift_en;
    assign bus.s_valid    = bit_fire;
    assign bus.s_data     = shift_q[bus_width-1];
    assign bus.load_ready = (state_q == IDLE);
    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // a load wins over shift_en; no bit is consumed on the accept edge
                if (bus.load_valid) begin
                    shift_d = bus.p_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_fire) begin
                    shift_d = {shift_q[bus_width-2:0], 1'b0};
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serializer.sv
// Directed and randomized checks of the serializer against a frame-level reference model
// that tracks the accepted word and how many of its bits remain to be sent.
module tb_serializer;
    localparam int BW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serializer_if #(.bus_width(BW)) bus ();
    serializer #(.bus_width(BW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic          m_busy;
    logic          m_done;
    logic [BW-1:0] m_word;
    int            m_left;
    logic [BW-1:0] rx;
    int            rx_cnt;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_word = '0;
        m_left = 0;
        rx     = '0;
        rx_cnt = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic lv, input logic [BW-1:0] pd, input logic se);
        logic exp_sdata;
        @(negedge clk);
        bus.load_valid = lv;
        bus.p_data     = pd;
        bus.shift_en   = se;
        #1;
        exp_sdata = m_busy ? m_word[m_left-1] : 1'b0;
        chk1("load_ready", bus.load_ready, !m_busy);
        chk1("busy", bus.busy, m_busy);
        chk1("s_valid", bus.s_valid, m_busy && se);
        chk1("s_data", bus.s_data, exp_sdata);
        chk1("done", bus.done, m_done);
        if (bus.s_valid === 1'b1) begin
            rx = {rx[BW-2:0], bus.s_data};
            rx_cnt++;
        end
        m_done = 1'b0;
        if (m_busy) begin
            if (se) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    chk8("frame_word", rx, m_word);
                    chk_int("frame_len", rx_cnt, BW);
                end
            end
        end else if (lv) begin
            m_busy = 1'b1;
            m_word = pd;
            m_left = BW;
            rx     = '0;
            rx_cnt = 0;
        end
    endtask

    // Assert reset asynchronously mid-cycle, check forced outputs, release on the next negedge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        bus.load_valid = 1'b0;
        bus.p_data     = '0;
        bus.shift_en   = 1'b1;
        #1;
        chk1("rst_load_ready", bus.load_ready, 1'b1);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_s_valid", bus.s_valid, 1'b0);
        chk1("rst_s_data", bus.s_data, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n        = 1'b1;
        bus.shift_en = 1'b0;
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.p_data     = '0;
        bus.shift_en   = 1'b0;
        model_reset();

        // power-on reset, then idle with shift_en ignored
        do_reset();
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);

        // 0xA5, shift_en held high (also load and shift_en together on the accept cycle)
        cycle(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < BW + 2; i++) cycle(1'b0, 8'h00, 1'b1);

        // 0x3C, shift_en toggling every cycle
        cycle(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 2 * BW + 2; i++) cycle(1'b0, 8'h00, 1'(i % 2 == 0));

        // 0xFF, then 0x00 offered throughout the frame
        cycle(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < BW; i++) cycle(1'b1, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // 0x81 abandoned after 3 bits, then a fresh 0x5A right after release
        cycle(1'b1, 8'h81, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        do_reset();
        cycle(1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < BW + 2; i++) cycle(1'b0, 8'h00, 1'b1);

        // back-to-back 0x12 then 0x34, load_valid held high
        for (int i = 0; i < 2 * BW + 2; i++)
            cycle(1'(i < BW + 2), (i < BW + 1) ? 8'h12 : 8'h34, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 2 * BW + 2; i++) cycle(1'b0, 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter: bus_width, 8, frame width in bits; legal values are 2 and above.
REQ-002 Parameter: counter_reg, $clog2(bus_width), bit-counter width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 load_valid  input  1  upstream presents a parallel word.
REQ-006 p_data  input  bus_width  parallel word to transmit.
REQ-007 shift_en  input  1  bit-rate strobe; one bit is transmitted per cycle with shift_en=1.
REQ-008 load_ready  output  1  block can accept a word.
REQ-009 s_data  output  1  serial data, MSB first, feeding the downstream parallelizer s_data.
REQ-010 s_valid  output  1  bit-valid strobe, driving the downstream parallelizer enable.
REQ-011 busy  output  1  frame in progress.
REQ-012 done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-013 The FSM SHALL have two states, IDLE and SHIFT, held in a register.
REQ-014 In IDLE, load_ready SHALL be 1 and busy SHALL be 0.
REQ-015 In SHIFT, load_ready SHALL be 0 and busy SHALL be 1.
REQ-016 Accept: load_valid=1 in IDLE SHALL capture p_data into the shift register, clear the bit counter and enter SHIFT on the same edge.
REQ-017 s_data SHALL equal shift_reg[bus_width-1] (registered MSB), so the word's MSB appears the cycle after acceptance.
REQ-018 s_valid SHALL be combinational: (state==SHIFT) AND shift_en.
REQ-019 On each edge with s_valid=1: shift left by one with 0 into the LSB; counter increments by 1.
REQ-020 In SHIFT with shift_en=0: shift register, counter and state SHALL hold.
REQ-021 Last bit: when s_valid=1 and counter==bus_width-1, the edge SHALL return to IDLE, clear the counter, and set done=1 for exactly one cycle.
REQ-022 Frame length: exactly bus_width s_valid pulses per accepted word, never more or fewer.
REQ-023 load_valid in SHIFT SHALL be ignored; the word is not captured and the frame is not disturbed.
REQ-024 shift_en in IDLE SHALL be ignored; s_valid stays 0.
REQ-025 load_valid and shift_en both high in IDLE: load only; no bit is consumed that cycle.
REQ-026 Back-to-back: load_ready is 1 in the done cycle, so a word offered then SHALL be accepted on that edge (no dead cycle beyond the done cycle).
REQ-027 Counter arithmetic SHALL be counter_reg bits wide, compared against bus_width-1, and SHALL never wrap within a frame.
REQ-028 Bit ordering SHALL match the parallelizer: after bus_width enabled shifts, the parallelizer's p_data equals the transmitted word.

Reset
REQ-029 rst=0 SHALL immediately force: state=IDLE, shift register=0, counter=0, s_data=0, done=0, busy=0, load_ready=1, s_valid=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no done pulse; the first post-reset accept starts a fresh frame from bit 0.
REQ-031 Release of rst SHALL take effect on the next rising clk edge with no additional latency.

Verification
REQ-032 Assert rst, then release with inputs idle -> load_ready=1, busy=0, s_data=0, s_valid=0, done=0.
REQ-033 Load 0xA5 with shift_en held at 1 -> s_data 1,0,1,0,0,1,0,1 on 8 consecutive s_valid cycles, then a one-cycle done pulse; the parallelizer p_data reads 0xA5.
REQ-034 Load 0x3C with shift_en toggling every cycle -> 8 s_valid pulses spread over 16 cycles, bits 0,0,1,1,1,1,0,0, done after the 8th pulse.
REQ-035 Load 0xFF, then drive load_valid with 0x00 during SHIFT -> 0x00 ignored, eight 1s transmitted, load_ready=0 throughout the frame.
REQ-036 Load 0x81 and pulse rst low after 3 bits -> outputs at reset values, no done pulse; a following load of 0x5A transmits all 8 bits correctly.
REQ-037 Keep load_valid high with 0x12 then 0x34 -> the second word is accepted in the done cycle, giving 16 contiguous bits 0x12 then 0x34 and two done pulses.
